// File: rtl/ram_io_responder.sv
// Byte-bus responder for the cpu: 128KB RAM plus an I/O window at mem_a[17:16]==2'b11 holding
// RX/TX byte FIFOs, a free-running cycle counter with coherent snapshot, and a program-stop flag.
module ram_io_responder #(
  parameter int unsigned RAM_AW      = 17,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RX_DEPTH    = 16,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        prog_done,
  output logic        tx_overflow
);

  localparam int unsigned RamSize = 1 << RAM_AW;
  localparam int unsigned TxAw    = $clog2(TX_DEPTH);
  localparam int unsigned RxAw    = $clog2(RX_DEPTH);

  localparam logic [TxAw:0]   TxFull   = (TxAw + 1)'(TX_DEPTH);
  localparam logic [TxAw:0]   TxNear   = (TxAw + 1)'(TX_DEPTH - FULL_MARGIN);
  localparam logic [TxAw:0]   TxCntOne = (TxAw + 1)'(1);
  localparam logic [TxAw-1:0] TxPtrOne = TxAw'(1);
  localparam logic [RxAw:0]   RxFull   = (RxAw + 1)'(RX_DEPTH);
  localparam logic [RxAw:0]   RxCntOne = (RxAw + 1)'(1);
  localparam logic [RxAw-1:0] RxPtrOne = RxAw'(1);

  logic [7:0] ram [RamSize];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];

  logic [7:0]      ram_rd_q;
  logic            sel_ram_q;
  logic [7:0]      io_din_q, io_din_d;
  logic            rx_rd_prev_q;
  logic [31:0]     cycle_cnt_q;
  logic [31:0]     snap_q;
  logic            prog_done_q;
  logic            tx_overflow_q;
  logic [TxAw:0]   tx_cnt_q;
  logic [TxAw-1:0] tx_rptr_q, tx_wptr_q;
  logic [RxAw:0]   rx_cnt_q;
  logic [RxAw-1:0] rx_rptr_q, rx_wptr_q;

  logic [17:0] addr;
  logic        io_sel, io_rd_rx, io_rd_cnt, io_wr_tx, io_wr_done;
  logic        tx_pop, tx_space, tx_push, ovf_set;
  logic [7:0]  tx_push_data;
  logic        rx_pop, rx_push;
  logic        unused_bits;

  assign addr       = mem_a[17:0];
  assign io_sel     = (addr[17:16] == 2'b11);
  assign io_rd_rx   = io_sel && !mem_wr && (addr[15:0] == 16'h0000);
  assign io_rd_cnt  = io_sel && !mem_wr && (addr[15:0] == 16'h0004);
  assign io_wr_tx   = io_sel && mem_wr && (addr[15:0] == 16'h0000) && (mem_dout != 8'h00);
  assign io_wr_done = io_sel && mem_wr && (addr[15:0] == 16'h0004);

  assign tx_valid       = (tx_cnt_q != '0);
  assign tx_data        = tx_mem[tx_rptr_q];
  assign io_buffer_full = (tx_cnt_q >= TxNear);
  assign rx_ready       = (rx_cnt_q != RxFull);
  assign prog_done      = prog_done_q;
  assign tx_overflow    = tx_overflow_q;
  assign mem_din        = sel_ram_q ? ram_rd_q : io_din_q;

  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign tx_pop       = tx_valid && tx_ready;
  assign tx_space     = (tx_cnt_q != TxFull) || tx_pop;
  assign tx_push      = (io_wr_tx || io_wr_done) && tx_space;
  assign tx_push_data = io_wr_done ? 8'h00 : mem_dout;
  assign ovf_set      = io_wr_tx && !tx_space;

  // Only the first read of a back-to-back run on the RX port consumes a byte.
  assign rx_pop  = io_rd_rx && !rx_rd_prev_q && (rx_cnt_q != '0);
  assign rx_push = rx_valid && rx_ready;

  assign unused_bits = ^{mem_a[31:18], snap_q[7:0]};

  always_comb begin
    io_din_d = 8'h00;
    if (io_sel && !mem_wr) begin
      case (addr[15:0])
        16'h0000: begin
          if (rx_rd_prev_q) io_din_d = io_din_q;
          else if (rx_cnt_q != '0) io_din_d = rx_mem[rx_rptr_q];
          else io_din_d = 8'h00;
        end
        16'h0004: io_din_d = cycle_cnt_q[7:0];
        16'h0005: io_din_d = snap_q[15:8];
        16'h0006: io_din_d = snap_q[23:16];
        16'h0007: io_din_d = snap_q[31:24];
        default:  io_din_d = 8'h00;
      endcase
    end
  end

  // RAM contents are never reset; read-first port with one cycle of latency.
  always_ff @(posedge clk_in) begin
    if (mem_wr && !io_sel) ram[mem_a[RAM_AW-1:0]] <= mem_dout;
    ram_rd_q <= ram[mem_a[RAM_AW-1:0]];
  end

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wptr_q] <= tx_push_data;
    if (rx_push) rx_mem[rx_wptr_q] <= rx_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_ram_q     <= 1'b0;
      io_din_q      <= 8'h00;
      rx_rd_prev_q  <= 1'b0;
      cycle_cnt_q   <= 32'h0;
      snap_q        <= 32'h0;
      prog_done_q   <= 1'b0;
      tx_overflow_q <= 1'b0;
      tx_cnt_q      <= '0;
      tx_rptr_q     <= '0;
      tx_wptr_q     <= '0;
      rx_cnt_q      <= '0;
      rx_rptr_q     <= '0;
      rx_wptr_q     <= '0;
    end else begin
      sel_ram_q    <= !io_sel && !mem_wr;
      io_din_q     <= io_din_d;
      rx_rd_prev_q <= io_rd_rx;
      if (io_rd_cnt) snap_q <= cycle_cnt_q;
      if (!prog_done_q) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (io_wr_done) prog_done_q <= 1'b1;
      if (ovf_set) tx_overflow_q <= 1'b1;

      if (tx_push) tx_wptr_q <= tx_wptr_q + TxPtrOne;
      if (tx_pop) tx_rptr_q <= tx_rptr_q + TxPtrOne;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + TxCntOne;
        2'b01:   tx_cnt_q <= tx_cnt_q - TxCntOne;
        default: tx_cnt_q <= tx_cnt_q;
      endcase

      if (rx_push) rx_wptr_q <= rx_wptr_q + RxPtrOne;
      if (rx_pop) rx_rptr_q <= rx_rptr_q + RxPtrOne;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + RxCntOne;
        2'b01:   rx_cnt_q <= rx_cnt_q - RxCntOne;
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

endmodule
